// File: rtl/varredura_displays.sv
// Four-digit multiplexed display scanner with blanking between digits and
// frame-synchronous loading of new digit patterns (double-buffered).
module varredura_displays #(
  parameter int          DIVISOR = 50000,
  parameter int          APAGAR  = 2,
  parameter logic [7:0]  APAGADO = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic       atualizar,
  input  logic [7:0] segmentosA,
  input  logic [7:0] segmentosB,
  input  logic [7:0] segmentosC,
  input  logic [7:0] segmentosD,
  output logic [3:0] displays,
  output logic [7:0] segmentos,
  output logic       ocupado,
  output logic       quadro
);

  localparam int            CW      = $clog2(DIVISOR);
  localparam logic [CW-1:0] ULTIMO  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] LIMIAR  = CW'(APAGAR);

  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      idx, idx_n;
  logic [3:0][7:0] ativo, ativo_n;
  logic [3:0][7:0] pendente, pendente_n;
  logic [3:0][7:0] entrada;
  logic            ocupado_n, quadro_n;
  logic [3:0]      displays_n;
  logic [7:0]      segmentos_n;
  logic            virada;

  // Index 0 is digit A, so the one-hot select is 4'b1000 >> idx.
  assign entrada = {segmentosD, segmentosC, segmentosB, segmentosA};
  assign virada  = habilitar && (idx == 2'd3) && (cnt == ULTIMO);

  always_comb begin
    cnt_n      = cnt;
    idx_n      = idx;
    ativo_n    = ativo;
    pendente_n = pendente;
    ocupado_n  = ocupado;
    quadro_n   = 1'b0;
    if (!habilitar) begin
      // Not scanning, so there is no frame to protect: loads apply at once.
      cnt_n     = '0;
      idx_n     = 2'd0;
      ocupado_n = 1'b0;
      if (atualizar)    ativo_n = entrada;
      else if (ocupado) ativo_n = pendente;
    end else begin
      if (cnt == ULTIMO) begin
        cnt_n = '0;
        idx_n = idx + 2'd1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      if (virada) begin
        quadro_n  = 1'b1;
        ocupado_n = 1'b0;
        if (atualizar)    ativo_n = entrada;
        else if (ocupado) ativo_n = pendente;
      end else if (atualizar) begin
        pendente_n = entrada;
        ocupado_n  = 1'b1;
      end
    end
    // Outputs are registered from next-state values so they track cnt/idx exactly.
    if (habilitar && (cnt_n >= LIMIAR)) begin
      displays_n  = 4'b1000 >> idx_n;
      segmentos_n = ativo_n[idx_n];
    end else begin
      displays_n  = 4'b0000;
      segmentos_n = APAGADO;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= 2'd0;
      ativo     <= '0;
      pendente  <= '0;
      ocupado   <= 1'b0;
      quadro    <= 1'b0;
      displays  <= 4'b0000;
      segmentos <= APAGADO;
    end else begin
      cnt       <= cnt_n;
      idx       <= idx_n;
      ativo     <= ativo_n;
      pendente  <= pendente_n;
      ocupado   <= ocupado_n;
      quadro    <= quadro_n;
      displays  <= displays_n;
      segmentos <= segmentos_n;
    end
  end

endmodule

// File: tb/tb_varredura_displays.sv
// Bench for varredura_displays (DIVISOR=8, APAGAR=2): stimulus pushes the
// hand-derived per-cycle output word, a negedge monitor pops and compares.
module tb_varredura_displays;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilitar;
  logic       atualizar;
  logic [7:0] segmentosA, segmentosB, segmentosC, segmentosD;
  logic [3:0] displays;
  logic [7:0] segmentos;
  logic       ocupado;
  logic       quadro;

  logic [13:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          n_pop  = 0;
  logic        exp_ocup = 1'b0;

  varredura_displays #(.DIVISOR(8), .APAGAR(2), .APAGADO(8'h00)) dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .atualizar(atualizar),
    .segmentosA(segmentosA), .segmentosB(segmentosB),
    .segmentosC(segmentosC), .segmentosD(segmentosD),
    .displays(displays), .segmentos(segmentos), .ocupado(ocupado), .quadro(quadro)
  );

  always #5 clock = ~clock;

  // Monitor: word layout is {displays, segmentos, ocupado, quadro}.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if ({displays, segmentos, ocupado, quadro} !== e) begin
        n_miss++;
        $display("FAIL scan[%0d]: got disp=%b seg=%h ocup=%b quadro=%b, expected disp=%b seg=%h ocup=%b quadro=%b",
                 n_pop, displays, segmentos, ocupado, quadro, e[13:10], e[9:2], e[1], e[0]);
      end
      n_pop++;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step(input logic [13:0] e);
    @(posedge clock);
    #1;
    exp_q.push_back(e);
    atualizar = 1'b0;
  endtask

  // One digit slot from counter c0 to c1; ld_c is the counter value produced
  // by the edge that samples a load (-1 for none).
  task automatic slot(input logic [3:0] oh, input logic [7:0] seg, input bit wrap,
                      input int c0, input int c1, input int ld_c, input logic [31:0] ld_v);
    for (int c = c0; c <= c1; c++) begin
      bit q;
      if (c == ld_c) begin
        {segmentosA, segmentosB, segmentosC, segmentosD} = ld_v;
        atualizar = 1'b1;
      end
      q = (c == 0) && wrap;
      if (q) exp_ocup = 1'b0;
      if ((c == ld_c) && !q) exp_ocup = 1'b1;
      step({(c >= 2) ? oh : 4'b0000, (c >= 2) ? seg : 8'h00, exp_ocup, q});
    end
  endtask

  initial begin
    reset = 1'b1; habilitar = 1'b0; atualizar = 1'b0;
    {segmentosA, segmentosB, segmentosC, segmentosD} = 32'h0;
    #2;
    check("reset_displays", {4'b0, displays}, 8'h00);
    check("reset_segmentos", segmentos, 8'h00);
    check("reset_ocupado", {7'b0, ocupado}, 8'h00);
    check("reset_quadro", {7'b0, quadro}, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Load while disabled goes straight to the active registers.
    {segmentosA, segmentosB, segmentosC, segmentosD} = 32'h11223344;
    atualizar = 1'b1;
    step({4'b0000, 8'h00, 1'b0, 1'b0});
    habilitar = 1'b1;

    // Frame 1: plain scan order.
    slot(4'b1000, 8'h11, 0, 1, 7, -1, 0);
    slot(4'b0100, 8'h22, 0, 0, 7, -1, 0);
    slot(4'b0010, 8'h33, 0, 0, 7, -1, 0);
    slot(4'b0001, 8'h44, 0, 0, 7, -1, 0);
    // Frame 2: load during slot B, old values kept to frame end.
    slot(4'b1000, 8'h11, 1, 0, 7, -1, 0);
    slot(4'b0100, 8'h22, 0, 0, 7, 3, 32'hAABBCCDD);
    slot(4'b0010, 8'h33, 0, 0, 7, -1, 0);
    slot(4'b0001, 8'h44, 0, 0, 7, -1, 0);
    // Frame 3: new values; two loads, last one wins.
    slot(4'b1000, 8'hAA, 1, 0, 7, -1, 0);
    slot(4'b0100, 8'hBB, 0, 0, 7, 4, 32'h01020304);
    slot(4'b0010, 8'hCC, 0, 0, 7, 5, 32'h05060708);
    slot(4'b0001, 8'hDD, 0, 0, 7, -1, 0);
    // Frame 4.
    slot(4'b1000, 8'h05, 1, 0, 7, -1, 0);
    slot(4'b0100, 8'h06, 0, 0, 7, -1, 0);
    slot(4'b0010, 8'h07, 0, 0, 7, -1, 0);
    slot(4'b0001, 8'h08, 0, 0, 7, -1, 0);
    // Frame 5: load coincident with the wrap, then enable drop in slot C.
    slot(4'b1000, 8'h99, 1, 0, 7, 0, 32'h99887766);
    slot(4'b0100, 8'h88, 0, 0, 7, -1, 0);
    slot(4'b0010, 8'h77, 0, 0, 4, 3, 32'h5A6B7C8D);
    habilitar = 1'b0;
    exp_ocup  = 1'b0;
    step({4'b0000, 8'h00, 1'b0, 1'b0});
    {segmentosA, segmentosB, segmentosC, segmentosD} = 32'h1A2B3C4D;
    atualizar = 1'b1;
    step({4'b0000, 8'h00, 1'b0, 1'b0});
    step({4'b0000, 8'h00, 1'b0, 1'b0});
    habilitar = 1'b1;
    // Frame 6: restart at slot A with the value loaded while disabled.
    slot(4'b1000, 8'h1A, 0, 1, 7, -1, 0);
    slot(4'b0100, 8'h2B, 0, 0, 7, -1, 0);
    slot(4'b0010, 8'h3C, 0, 0, 7, -1, 0);
    slot(4'b0001, 8'h4D, 0, 0, 7, -1, 0);
    // Frame 7: pending load, then asynchronous reset mid-show.
    slot(4'b1000, 8'h1A, 1, 0, 5, 3, 32'hF0F1F2F3);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("async_displays", {4'b0, displays}, 8'h00);
    check("async_segmentos", segmentos, 8'h00);
    check("async_ocupado", {7'b0, ocupado}, 8'h00);
    check("async_quadro", {7'b0, quadro}, 8'h00);
    reset = 1'b0;
    exp_ocup = 1'b0;
    // After reset: cleared registers, pending load discarded.
    slot(4'b1000, 8'h00, 0, 1, 7, -1, 0);
    slot(4'b0100, 8'h00, 0, 0, 7, -1, 0);
    slot(4'b0010, 8'h00, 0, 0, 7, -1, 0);
    slot(4'b0001, 8'h00, 0, 0, 7, -1, 0);
    slot(4'b1000, 8'h00, 1, 0, 7, -1, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected words left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/varredura_displays.md
VARREDURA_DISPLAYS -- requirements
Module: varredura_displays

Interface
REQ-001 Parameter DIVISOR, default 50000: clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter APAGAR, default 2: blanking cycles at the start of each slot; legal range 1..DIVISOR-2.
REQ-003 Parameter APAGADO, default 8'h00: segment value driven while blanked.
REQ-004 Port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port habilitar, input, 1: scan enable.
REQ-007 Port atualizar, input, 1: single-cycle request to load new digit values.
REQ-008 Ports segmentosA, segmentosB, segmentosC, segmentosD, input, 8 each: new digit patterns, sampled only when atualizar=1.
REQ-009 Port displays, output, 4: one-hot digit select; A=4'b1000, B=4'b0100, C=4'b0010, D=4'b0001; 4'b0000 when blanked.
REQ-010 Port segmentos, output, 8: segment pattern of the selected digit.
REQ-011 Port ocupado, output, 1: a load is pending and not yet applied.
REQ-012 Port quadro, output, 1: one-cycle pulse at the end of each complete A-B-C-D frame.

Function
REQ-013 Slot counter counts 0..DIVISOR-1 and wraps to 0; the digit index advances A->B->C->D->A on each wrap.
REQ-014 Counter values 0..APAGAR-1 form the BLANK phase: displays=0 and segmentos=APAGADO.
REQ-015 Counter values APAGAR..DIVISOR-1 form the SHOW phase: displays=one-hot of the current index and segmentos=active register of that index.
REQ-016 All outputs are registered, with no combinational path from any input to any output.
REQ-017 atualizar=1 on a clock edge copies segmentosA..D into the pending registers and sets ocupado=1 on the next cycle.
REQ-018 If atualizar is asserted again while ocupado=1, the pending registers are overwritten (last write wins) and ocupado stays 1.
REQ-019 Pending values transfer to the active registers on the D->A wrap edge, and ocupado clears on that edge.
REQ-020 If atualizar and the D->A wrap fall on the same edge, the newly sampled values go directly to the active registers and ocupado=0.
REQ-021 Active registers never change mid-frame, so all four digits of a frame come from one load.
REQ-022 quadro=1 for exactly the one cycle following the D->A wrap edge, and is 0 otherwise.
REQ-023 habilitar=0 forces the counter to 0 and the index to A, drives displays=0 and segmentos=APAGADO, and holds quadro=0.
REQ-024 While habilitar=0, a pending load applies on the next edge; atualizar is still accepted and applied immediately.
REQ-025 When habilitar rises, scanning restarts at counter 0 of slot A, beginning in the BLANK phase.
REQ-026 The frame period is exactly 4*DIVISOR cycles and each digit is lit for DIVISOR-APAGAR cycles per frame.

Reset
REQ-027 With reset=1, outputs are immediately (asynchronously) displays=0, segmentos=APAGADO, ocupado=0, quadro=0.
REQ-028 With reset=1, counter=0, index=A, and the active and pending registers are all 8'h00.
REQ-029 A reset asserted mid-slot or mid-load discards the pending load, with no partial update.
REQ-030 On the first edge after reset release (habilitar=1), the block begins BLANK phase of slot A.

Verification (DIVISOR=8, APAGAR=2, APAGADO=8'h00)
REQ-031 Scan order:
- Stimulus: reset, then a load of A=8'h11, B=8'h22, C=8'h33, D=8'h44, habilitar=1.
- Response: each frame shows 2 cycles blank, then 6 cycles of displays=8/segmentos=11, then the same pattern for 4/22, 2/33 and 1/44.
- quadro pulses every 32 cycles.
REQ-032 Mid-frame load:
- Stimulus: atualizar with 8'hAA..8'hDD during slot B.
- Response: slots C and D still show 33/44, ocupado=1 until the D->A wrap, and the next frame shows AA,BB,CC,DD.
REQ-033 Double load:
- Stimulus: two atualizar pulses in one frame with different values.
- Response: only the second set appears at the next frame, and ocupado clears once.
REQ-034 Coincident load and wrap:
- Stimulus: atualizar on the D->A wrap edge.
- Response: the new values are shown in slot A of the starting frame, and ocupado stays 0.
REQ-035 Enable drop:
- Stimulus: habilitar=0 during slot C, then habilitar=1.
- Response: displays=0 and segmentos=00 while disabled; after re-enable, 2 blank cycles, then displays=8.
REQ-036 Asynchronous reset:
- Stimulus: reset asserted between clock edges during a SHOW phase.
- Response: displays=0 immediately, ocupado=0, and after release a blank slot A with segmentos=00.
